box_window_reader: RTL
======================

Name: box_window_reader

Overview:
- Read-side controller for the three pixel line-buffer FIFOs feeding the 3x3 box blur kernel.
- Waits until all three line FIFOs report programmable-full, then drains one full line from each in lockstep.
- Shifts the returned pixels into a 3x3 column-shift window and presents each valid window downstream under a valid/ready handshake.
- Sits between the line FIFOs (consumer of their outPixel/outPixelValid/progFull) and the blur arithmetic.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_WIDTH, 16, pixels per line; equals line FIFO depth; minimum 3.
- CNT_WIDTH, 5, width of column/read counters; must hold LINE_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- lineData0  input  DATA_WIDTH  outPixel of top-row FIFO (oldest line).
- lineData1  input  DATA_WIDTH  outPixel of middle-row FIFO.
- lineData2  input  DATA_WIDTH  outPixel of bottom-row FIFO (newest line).
- lineValid  input  3  outPixelValid of FIFOs 2..0.
- lineFull  input  3  progFull of FIFOs 2..0.
- rdEn  output  3  read strobe to FIFOs 2..0; always all-ones or all-zeros.
- window  output  9*DATA_WIDTH  3x3 window, row-major; [DATA_WIDTH-1:0] = top-left, highest slice = bottom-right.
- windowValid  output  1  window holds a valid 3x3 neighbourhood.
- windowReady  input  1  downstream accepts window this cycle.
- lineDone  output  1  one-cycle pulse when the last window of a line is accepted.
- syncErr  output  1  sticky; lineValid bits disagreed.

Behaviour:
- Reset (rst=0, async): state=IDLE; rdEn=0; window=0; windowValid=0; lineDone=0; syncErr=0; all counters and skid register cleared. Reset mid-line abandons the line; there is no resume.
- FSM states: IDLE, READ, FLUSH.
- IDLE -> READ when lineFull==3'b111. rdCnt=0, colCnt=0.
- READ:
  - rdEn=3'b111 when rdCnt<LINE_WIDTH and no stall.
  - Stall = windowValid && !windowReady, or skid register occupied.
  - rdCnt increments on each issued read.
  - After LINE_WIDTH reads -> FLUSH.
- FLUSH: wait for in-flight data and the final window handshake. -> IDLE when colCnt==LINE_WIDTH and the last window is accepted (or no window is pending). lineDone pulses that cycle.
- FIFO read latency is 1 cycle: data arrives with lineValid the cycle after rdEn.
- Shift: on lineValid==3'b111 with no stall, column {lineData2,lineData1,lineData0} shifts in at the right edge of the window; the left column is discarded; colCnt increments.
- Skid: if data arrives while stalled, it is captured in a 1-entry skid register and shifted in on the first unstalled cycle, before any new FIFO data. At most one read is in flight, so the skid register never overflows.
- windowValid:
  - Set on the cycle a shift makes colCnt>=3.
  - Cleared on handshake (windowValid && windowReady) unless a shift occurs in the same cycle.
  - Simultaneous handshake and shift keep windowValid=1 with the new window (back-to-back throughput of 1 window/cycle).
- Windows per line = LINE_WIDTH-2; no edge padding.
- syncErr sets when lineValid is neither 3'b000 nor 3'b111. On that event the column is not shifted. syncErr stays set until reset.
- lineFull deasserting during READ is ignored; the read count is authoritative.
- colCnt saturates at LINE_WIDTH; surplus lineValid in FLUSH/IDLE is ignored and sets syncErr.

Optional Feature:
- WINDOW_SUM_EN defined:
  - Adds output windowSum, width DATA_WIDTH+4: the sum of all 9 window pixels.
  - Registered in the same cycle as window, so it is valid with windowValid.
  - Reset value 0.
  - Arithmetic is zero-extended unsigned; it cannot overflow.
- WINDOW_SUM_EN undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Fill: lineFull=3'b111, LINE_WIDTH=16, FIFO n returns pixel values 16n+i, windowReady=1 -> rdEn high 16 consecutive cycles. First windowValid 4 cycles after the first rdEn, with window = {34,33,32,18,17,16,2,1,0}. 14 windows total, lineDone pulses once, FSM returns to IDLE.
- Backpressure: windowReady low for 5 cycles after the first window -> rdEn drops within 1 cycle; the in-flight column is held in the skid register. After release, windows resume with no pixel lost or duplicated; 14 windows in order.
- Not ready: lineFull=3'b011 -> rdEn stays 0 and windowValid stays 0 indefinitely. Raising bit 2 starts the read on the next cycle.
- Sync error: lineValid=3'b101 on one cycle mid-line -> syncErr=1 and stays set; that column is not shifted.
- Reset mid-line: assert rst=0 after the 6th window -> all outputs 0 immediately. A fresh fill after release yields a correct first window.
- WINDOW_SUM_EN: all pixels=255 -> windowSum=2295 for every window; pixels 0..8 -> windowSum=36.

Source files
------------

// File: rtl/box_window_reader.sv
// ---------------------------------------------------------------------------
// box_window_reader
//
// Read-side controller for the three pixel line-buffer FIFOs that feed the
// 3x3 box blur. Once all three FIFOs report programmable-full it drains one
// line from each in lockstep. Each returned column is shifted into a 3x3
// column-shift window, and every valid window is offered downstream under a
// valid/ready handshake.
//
// Optional build macro: WINDOW_SUM_EN. When it is defined, the windowSum port
// is added. It carries the registered sum of the nine window pixels.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   lineData0..2 outPixel of top (oldest) / middle / bottom (newest) FIFO
//   lineValid    outPixelValid of FIFOs 2..0
//   lineFull     progFull of FIFOs 2..0
//   rdEn         read strobe to FIFOs 2..0 (all-ones or all-zeros)
//   window       3x3 window, row-major, [DATA_WIDTH-1:0] = top-left
//   windowValid  window holds a valid neighbourhood
//   windowReady  downstream accepts the window this cycle
//   lineDone     pulse on the cycle the last window of a line is accepted
//   syncErr      sticky: lineValid bits disagreed or surplus data arrived
//   windowSum    (WINDOW_SUM_EN only) sum of the nine window pixels
// ---------------------------------------------------------------------------
module box_window_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   lineData0,
    input  logic [DATA_WIDTH-1:0]   lineData1,
    input  logic [DATA_WIDTH-1:0]   lineData2,
    input  logic [2:0]              lineValid,
    input  logic [2:0]              lineFull,
    output logic [2:0]              rdEn,
    output logic [9*DATA_WIDTH-1:0] window,
    output logic                    windowValid,
    input  logic                    windowReady,
    output logic                    lineDone,
`ifdef WINDOW_SUM_EN
    output logic [DATA_WIDTH+3:0]   windowSum,
`endif
    output logic                    syncErr
);

    localparam int COL_W = 3 * DATA_WIDTH;
    localparam int WIN_W = 9 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LINE_LAST = CNT_WIDTH'(LINE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] FIRST_WIN = CNT_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT                  stateR;
    logic [CNT_WIDTH-1:0]   rdCntR;
    logic [CNT_WIDTH-1:0]   colCntR;
    logic                   skidValidR;
    logic [COL_W-1:0]       skidDataR;

    logic                   outStallS;
    logic                   allValidS;
    logic                   patternErrS;
    logic [CNT_WIDTH-1:0]   colTotalS;
    logic                   surplusS;
    logic                   inValidS;
    logic                   shiftS;
    logic                   skidLoadS;
    logic                   readS;
    logic                   doneS;
    logic [COL_W-1:0]       colInS;
    logic [WIN_W-1:0]       nextWindowS;
    logic                   windowValidNextS;

`ifdef WINDOW_SUM_EN
    // Zero-extended sum of the nine pixels. Nine values below 2**DATA_WIDTH
    // always fit in DATA_WIDTH+4 bits.
    function automatic logic [DATA_WIDTH+3:0] sumPixels(input logic [WIN_W-1:0] w);
        logic [DATA_WIDTH+3:0] acc;
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + {4'b0000, w[i*DATA_WIDTH +: DATA_WIDTH]};
        end
        return acc;
    endfunction
`endif

    // Handshake, stall, skid and next-window decode.
    always_comb begin
        outStallS   = windowValid && !windowReady;
        allValidS   = (lineValid == 3'b111);
        patternErrS = (lineValid != 3'b000) && (lineValid != 3'b111);
        // A column still waiting in the skid register is already received,
        // so it counts toward the line total.
        colTotalS   = colCntR + {{(CNT_WIDTH-1){1'b0}}, skidValidR};
        surplusS    = allValidS && ((stateR == IDLE) || (colTotalS >= LINE_LAST));
        inValidS    = allValidS && !surplusS;
        shiftS      = !outStallS && (skidValidR || inValidS);
        // A skid entry is always older than anything arriving now.
        colInS      = skidValidR ? skidDataR : {lineData2, lineData1, lineData0};
        skidLoadS   = inValidS && (outStallS || skidValidR);
        // rdEn depends on windowReady in the same cycle. Because of this, a
        // read is only issued in an unstalled cycle, so at most one column
        // can land in the skid register.
        readS       = (stateR == READ) && (rdCntR < LINE_LAST) && !outStallS && !skidValidR;
        doneS       = (stateR == FLUSH) && (colCntR == LINE_LAST) && (!windowValid || windowReady);

        nextWindowS = window;
        if (shiftS) begin
            for (int r = 0; r < 3; r++) begin
                nextWindowS[(r*3+0)*DATA_WIDTH +: DATA_WIDTH] = window[(r*3+1)*DATA_WIDTH +: DATA_WIDTH];
                nextWindowS[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] = window[(r*3+2)*DATA_WIDTH +: DATA_WIDTH];
                nextWindowS[(r*3+2)*DATA_WIDTH +: DATA_WIDTH] = colInS[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            nextWindowS = window;
        end

        if (shiftS && ((colCntR + CNT_ONE) >= FIRST_WIN)) begin
            windowValidNextS = 1'b1;
        end else if (windowValid && windowReady) begin
            windowValidNextS = 1'b0;
        end else begin
            windowValidNextS = windowValid;
        end
    end

    assign rdEn     = readS ? 3'b111 : 3'b000;
    assign lineDone = doneS;

    // State machine, counters, skid register, window and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR      <= IDLE;
            rdCntR      <= '0;
            colCntR     <= '0;
            skidValidR  <= 1'b0;
            skidDataR   <= '0;
            window      <= '0;
            windowValid <= 1'b0;
            syncErr     <= 1'b0;
        end else begin
            syncErr     <= syncErr || patternErrS || surplusS;
            window      <= nextWindowS;
            windowValid <= windowValidNextS;

            if (skidLoadS) begin
                skidValidR <= 1'b1;
                skidDataR  <= {lineData2, lineData1, lineData0};
            end else if (shiftS) begin
                skidValidR <= 1'b0;
            end else begin
                skidValidR <= skidValidR;
            end

            if (shiftS) begin
                colCntR <= colCntR + CNT_ONE;
            end else begin
                colCntR <= colCntR;
            end

            if (readS) begin
                rdCntR <= rdCntR + CNT_ONE;
            end else begin
                rdCntR <= rdCntR;
            end

            case (stateR)
                IDLE: begin
                    if (lineFull == 3'b111) begin
                        stateR  <= READ;
                        rdCntR  <= '0;
                        colCntR <= '0;
                    end else begin
                        stateR <= IDLE;
                    end
                end
                READ: begin
                    // The read count alone ends the line; lineFull is not
                    // looked at again.
                    if (readS && ((rdCntR + CNT_ONE) == LINE_LAST)) begin
                        stateR <= FLUSH;
                    end else begin
                        stateR <= READ;
                    end
                end
                FLUSH: begin
                    if (doneS) begin
                        stateR <= IDLE;
                    end else begin
                        stateR <= FLUSH;
                    end
                end
                default: begin
                    stateR <= IDLE;
                end
            endcase
        end
    end

`ifdef WINDOW_SUM_EN
    // Sum registered alongside the window it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            windowSum <= '0;
        end else begin
            windowSum <= sumPixels(nextWindowS);
        end
    end
`endif

endmodule
